data_ff: RTL and testbench
==========================

Name: data_ff

Overview:
- Parameterised D flip-flop with synchronous clear and synchronous preset, plus complementary output.
- Leaf storage primitive used wherever a registered bit or word with forced set/clear is needed.
- All state changes occur only on the rising edge of clk; there are no asynchronous paths.

Parameters:
- WIDTH, 1, bit width of d, q and qb.
- PRESET_VAL, all ones ({WIDTH{1'b1}}), value loaded into q when the preset is taken.

Ports:
- clk  input  1  rising-edge clock; the single clock domain.
- clr  input  1  synchronous clear; this is the block reset. Active-low: clr=0 clears.
- pre  input  1  synchronous preset, active-high: pre=1 loads PRESET_VAL.
- d    input  WIDTH  data input.
- q    output  WIDTH  registered output.
- qb   output  WIDTH  bitwise complement of q.

Interface note: one clock; reset is synchronous and active-low (clk, clr).

Behaviour:
- Evaluated only at posedge clk, in priority order:
  1. clr==0: q <= 0 (reset/clear wins over everything).
  2. else pre==1: q <= PRESET_VAL.
  3. else: q <= d.
- qb = ~q at all times, combinationally derived from the q register, so it never disagrees with q.
- Reset value after any edge with clr==0: q=0, qb=all ones.
- Before the first rising edge, q is X.
  - No initial value is required.
  - Benches must not check q before the first edge that samples clr==0, or pre==1 with clr==1.
- Latency: one clock edge from an input change to the q update. Inputs changing between edges have no effect.
- Simultaneous events:
  - clr==0 with pre==1 gives q=0 (clear dominates).
  - pre==1 with any d gives PRESET_VAL.
- Holding clr low for many cycles keeps q=0. Release takes effect at the first edge that samples clr==1.
- X/Z on pre or d while clr==0 has no effect; q=0.
- Width rule: all bits update together. There is no per-bit enable and no hold state; d is sampled every cycle when not cleared or preset.
- No other outputs or status signals.

Test Plan:
(clk period 100 ns, rising edges at 50, 150, 250, 350 ns; inputs change at 0/100/200/300 ns.)
1. t=0: d=0, pre=1, clr=0 -> at edge 50 ns q=0, qb=1 (clear dominates preset).
2. t=100: d=0, pre=0, clr=1 -> at edge 150 ns q=0, qb=1 (d sampled).
3. t=200: d=0, pre=0, clr=0 -> at edge 250 ns q=0, qb=1 (clear).
4. t=300: d=1, pre=0, clr=0 -> at edge 350 ns q=0, qb=1 (clear overrides d=1).
5. Extra: clr=1, pre=1, d=0 -> next edge q=1, qb=0. Then pre=0, d=1 -> q=1. Then d=0 -> q=0. Each change appears exactly one edge after it is applied.
6. Extra: toggle d mid-cycle between edges while clr=1, pre=0 -> q changes only at the rising edge, and qb==~q throughout.

Source files
------------

// File: rtl/data_ff.sv
// data_ff: parameterised D flip-flop with synchronous active-low clear,
// synchronous active-high preset and a complementary output.
// Priority at each rising edge: clear, then preset, then load d.
module data_ff #(
  parameter int                 WIDTH      = 1,
  parameter logic [WIDTH-1:0]   PRESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pre,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);

  // Storage word; every bit updates on the same edge, there is no hold state.
  logic [WIDTH-1:0] r_q;

  // Complement is taken from the register itself so q and qb can never disagree.
  logic [WIDTH-1:0] w_qb;

  // Clear dominates preset, preset dominates data; pre and d are ignored while clearing.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_q <= '0;
    end else if (pre) begin
      r_q <= PRESET_VAL;
    end else begin
      r_q <= d;
    end
  end

  // Combinational complement of the stored word.
  always_comb begin
    w_qb = ~r_q;
  end

  assign q  = r_q;
  assign qb = w_qb;

endmodule

// File: tb/tb_data_ff.sv
// tb_data_ff: self-checking bench for data_ff. Two instances share clr/pre:
// a default 1-bit flop and an 8-bit flop with a non-trivial preset value.
// A behavioural model tracks the expected word for each instance.
module tb_data_ff;

  localparam logic [7:0] P8 = 8'hC3;

  logic       clk = 1'b0;
  logic       clr;
  logic       pre;
  logic [0:0] d1;
  logic [7:0] d8;
  logic [0:0] q1, qb1;
  logic [7:0] q8, qb8;

  logic [0:0] exp1;
  logic [7:0] exp8;

  int checks = 0;
  int errors = 0;

  always #50 clk = ~clk;

  data_ff u_dut1 (
    .clk (clk),
    .clr (clr),
    .pre (pre),
    .d   (d1),
    .q   (q1),
    .qb  (qb1)
  );

  data_ff #(.WIDTH(8), .PRESET_VAL(P8)) u_dut8 (
    .clk (clk),
    .clr (clr),
    .pre (pre),
    .d   (d8),
    .q   (q8),
    .qb  (qb8)
  );

  // Apply inputs half a period before an edge (or at t=0), take the edge,
  // then advance the model from the sampled inputs and settle 1 ns past it.
  task automatic drive_edge(input logic c, input logic p, input logic [0:0] a, input logic [7:0] b);
    if ($time != 0) @(negedge clk);
    clr = c; pre = p; d1 = a; d8 = b;
    @(posedge clk);
    if (clr === 1'b0) begin
      exp1 = 1'b0;
      exp8 = 8'h00;
    end else if (pre === 1'b1) begin
      exp1 = 1'b1;
      exp8 = P8;
    end else begin
      exp1 = d1;
      exp8 = d8;
    end
    #1;
    $display("txn t=%0t clr=%b pre=%b d1=%b d8=%h -> q1=%b q8=%h", $time, clr, pre, d1, d8, q1, q8);
  endtask

  // Directed sequence from the plan: clear dominance and clear overriding d.
  task automatic test_reset();
    drive_edge(1'b0, 1'b1, 1'b0, 8'hFF);
    checks++;
    if ({q1, qb1, q8, qb8} !== {1'b0, 1'b1, 8'h00, 8'hFF}) begin
      errors++;
      $display("FAIL reset_clr_over_pre: q1=%b qb1=%b q8=%h qb8=%h, required 0 1 00 ff", q1, qb1, q8, qb8);
    end
    drive_edge(1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({q1, qb1, q8, qb8} !== {1'b0, 1'b1, 8'h00, 8'hFF}) begin
      errors++;
      $display("FAIL reset_release_d0: q1=%b qb1=%b q8=%h qb8=%h, required 0 1 00 ff", q1, qb1, q8, qb8);
    end
    drive_edge(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({q1, qb1, q8, qb8} !== {1'b0, 1'b1, 8'h00, 8'hFF}) begin
      errors++;
      $display("FAIL reset_clear: q1=%b qb1=%b q8=%h qb8=%h, required 0 1 00 ff", q1, qb1, q8, qb8);
    end
    drive_edge(1'b0, 1'b0, 1'b1, 8'h5A);
    checks++;
    if ({q1, qb1, q8, qb8} !== {1'b0, 1'b1, 8'h00, 8'hFF}) begin
      errors++;
      $display("FAIL reset_clr_over_d: q1=%b qb1=%b q8=%h qb8=%h, required 0 1 00 ff", q1, qb1, q8, qb8);
    end
  endtask

  // Preset, then data loads, each visible exactly one edge after being applied.
  task automatic test_preset_and_data();
    drive_edge(1'b1, 1'b1, 1'b0, 8'h00);
    checks++;
    if ({q1, qb1, q8, qb8} !== {1'b1, 1'b0, P8, ~P8}) begin
      errors++;
      $display("FAIL preset: q1=%b q8=%h, required 1 %h", q1, q8, P8);
    end
    drive_edge(1'b1, 1'b0, 1'b1, 8'h3C);
    checks++;
    if ({q1, qb1, q8, qb8} !== {1'b1, 1'b0, 8'h3C, 8'hC3}) begin
      errors++;
      $display("FAIL data_load1: q1=%b q8=%h qb8=%h, required 1 3c c3", q1, q8, qb8);
    end
    drive_edge(1'b1, 1'b0, 1'b0, 8'h81);
    checks++;
    if ({q1, qb1, q8, qb8} !== {1'b0, 1'b1, 8'h81, 8'h7E}) begin
      errors++;
      $display("FAIL data_load0: q1=%b q8=%h qb8=%h, required 0 81 7e", q1, q8, qb8);
    end
  endtask

  // d toggles between edges must not reach q until the next rising edge.
  task automatic test_midcycle();
    logic [0:0] hold1;
    logic [7:0] hold8;
    drive_edge(1'b1, 1'b0, 1'b1, 8'hA5);
    hold1 = exp1;
    hold8 = exp8;
    for (int k = 0; k < 4; k++) begin
      #10;
      d1 = 1'($urandom);
      d8 = 8'($urandom);
      #1;
      checks++;
      if ({q1, qb1, q8, qb8} !== {hold1, ~hold1, hold8, ~hold8}) begin
        errors++;
        $display("FAIL midcycle_hold[%0d]: q1=%b q8=%h qb8=%h, required %b %h %h", k, q1, q8, qb8, hold1, hold8, ~hold8);
      end
    end
    drive_edge(1'b1, 1'b0, d1, d8);
    checks++;
    if ({q1, qb1, q8, qb8} !== {exp1, ~exp1, exp8, ~exp8}) begin
      errors++;
      $display("FAIL midcycle_edge: q1=%b q8=%h, required %b %h", q1, q8, exp1, exp8);
    end
  endtask

  // Long clear with unknown pre/d keeps q at zero; release loads on first clr=1 edge.
  task automatic test_hold_clear();
    for (int k = 0; k < 3; k++) begin
      drive_edge(1'b0, 1'bx, 1'bx, 8'hxx);
      checks++;
      if ({q1, qb1, q8, qb8} !== {1'b0, 1'b1, 8'h00, 8'hFF}) begin
        errors++;
        $display("FAIL clear_with_x[%0d]: q1=%b q8=%h qb8=%h, required 0 00 ff", k, q1, q8, qb8);
      end
    end
    drive_edge(1'b1, 1'b0, 1'b1, 8'hE7);
    checks++;
    if ({q1, qb1, q8, qb8} !== {1'b1, 1'b0, 8'hE7, 8'h18}) begin
      errors++;
      $display("FAIL clear_release: q1=%b q8=%h, required 1 e7", q1, q8);
    end
  endtask

  // Randomised mix of clear, preset and data against the model.
  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      drive_edge(($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0),
                 1'($urandom), 8'($urandom));
      checks++;
      if ({q1, qb1, q8, qb8} !== {exp1, ~exp1, exp8, ~exp8}) begin
        errors++;
        $display("FAIL random[%0d]: q1=%b qb1=%b q8=%h qb8=%h, required %b %b %h %h",
                 k, q1, qb1, q8, qb8, exp1, ~exp1, exp8, ~exp8);
      end
    end
  endtask

  initial begin
    clr = 1'b0; pre = 1'b0; d1 = 1'b0; d8 = 8'h00;
    exp1 = 1'b0; exp8 = 8'h00;
    test_reset();
    test_preset_and_data();
    test_midcycle();
    test_hold_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
